ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Parametrised multi-cycle execute unit for the RV32M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits beside the single-cycle ALU in the EX stage and accepts an op from ID/EX through a valid/ready handshake.
- Iterates a shift-add multiplier or restoring divider at BPC bits per cycle.
- Returns the result with its rd address to EX/MEM, and provides busy/forward information to ID for stall control.

Parameters:
- XLEN, 32, operand/result width in bits; must be even and ≥ 8.
- BPC, 1, bits retired per iteration cycle; must divide XLEN; allowed values 1, 2, 4.
- REGADDR_W, 5, register address width.

Ports:
- clk_in  in  1  clock; all state updates on rising edge.
- rst_in  in  1  asynchronous, active-high reset.
- rdy_in  in  1  global enable; when 0 all state holds, outputs hold.
- flush_in  in  1  branch-mispredict kill; discards any op in flight.
- in_valid  in  1  op presented by ID/EX.
- in_ready  out  1  unit can accept; high only in IDLE.
- op_in  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_in  in  XLEN  operand a.
- rs2_in  in  XLEN  operand b.
- rd_in  in  REGADDR_W  destination register.
- out_valid  out  1  result available.
- out_ready  in  1  EX/MEM consumes the result.
- result_o  out  XLEN  result data.
- rd_o  out  REGADDR_W  destination of result_o.
- busy_o  out  1  op accepted and not yet consumed; ID stalls dependents.
- busy_rd_o  out  REGADDR_W  rd of the in-flight op (0 when idle).

Behaviour:
- Reset (async, rst_in=1): state=IDLE.
  - in_ready=0 during reset, 1 after.
  - out_valid=0, result_o=0, rd_o=0, busy_o=0, busy_rd_o=0.
  - Counter and datapath registers cleared.
- FSM states: IDLE, CALC, DONE.
- Accept: in IDLE with in_valid=1, rdy_in=1 and flush_in=0, latch op, operands and rd.
  - Special case present: go to DONE next edge (latency 1).
  - Otherwise: go to CALC.
- Special cases:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = rs1.
  - Signed overflow (rs1 = most negative, rs2 = −1): DIV = rs1; REM = 0.
  - MUL ops have no special case.
- CALC: runs exactly XLEN/BPC cycles; the counter decrements each enabled cycle.
  - On the last iteration, sign correction is applied and the result registered; state goes to DONE.
  - Accept-to-out_valid latency = 1 + XLEN/BPC cycles (33 for XLEN=32, BPC=1).
- Signed handling:
  - Operands are converted to magnitude at accept: rs1 for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM.
  - The result is negated at completion when the signs differ (quotient, products).
  - The remainder takes the sign of the dividend.
- Multiply: 2·XLEN-bit product accumulated.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide: restoring, one quotient bit per sub-step, BPC sub-steps per cycle.
- DONE: out_valid=1 with stable result_o and rd_o until out_ready=1.
  - On consume: go to IDLE; out_valid drops next edge. There is no back-to-back accept in the same cycle.
- busy_o = (state != IDLE); busy_rd_o = latched rd while busy.
  - rd=0 results still complete normally; the consumer ignores x0 writes.
- flush_in=1 (rdy_in=1), any state: next edge state=IDLE, out_valid=0, busy_o=0.
  - Flush wins over a simultaneous accept or consume.
- rdy_in=0: counter, FSM and registers frozen. Flush and handshakes are ignored that cycle; outputs hold.
- Reset mid-CALC: immediate return to the reset values above; no partial result is visible.
- All arithmetic is modulo 2^XLEN; the counter width is clog2(XLEN/BPC + 1).

Decomposition:
- Shared package or define header:
  - MULDIV op encodings (funct3 values).
  - FSM state encoding.
  - XLEN default.
  - Special-result constants (all-ones, most-negative).
- One natural sub-module: muldiv_core_step.
  - Purely combinational BPC-wide iteration step (shift-add or restore-subtract).
  - Instantiated once and selected by an op class bit.

Test Plan:
- MUL 7 × −3 (rs1=7, rs2=0xFFFFFFFD), out_ready=1 → after 33 cycles result_o=0xFFFFFFEB, out_valid pulses 1 cycle, rd_o=rd_in.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULH same operands → 0x00000000; MULHSU(−1, 0xFFFFFFFF) → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 % 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2.
- DIV 5/0 → 0xFFFFFFFF and REM 5%0 → 5, each with out_valid 1 cycle after accept; DIV 0x80000000 / −1 → 0x80000000, REM → 0.
- Handshake and rdy:
  - Hold out_ready=0 for 5 cycles in DONE → result, rd and busy_o stable; in_ready=0.
  - rdy_in=0 for 4 cycles mid-CALC → completion delayed exactly 4 cycles with the same result.
- Flush mid-CALC at cycle 10, and flush coincident with out_ready → IDLE next cycle, out_valid never asserts, busy_o=0; a new op then completes correctly. Also assert rst_in mid-CALC → all outputs 0 immediately.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// ex_muldiv_unit_pkg
// Shared definitions for the RV32M multiply/divide execute unit:
//   - funct3 op encodings for MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   - FSM state encoding (IDLE, CALC, DONE)
//   - default operand width and the special-result constants at that width
//   - helpers that decide which operands are treated as signed
package ex_muldiv_unit_pkg;

    localparam int XLEN_DEF = 32;

    // funct3 encodings. Bit 2 marks the divide class, and within the divide
    // class bit 1 selects the remainder.
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    // FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Special-result constants at the default width; the unit derives its
    // own XLEN-wide versions from the same patterns.
    localparam logic [XLEN_DEF-1:0] ALL_ONES_DEF = {XLEN_DEF{1'b1}};
    localparam logic [XLEN_DEF-1:0] MOST_NEG_DEF = {1'b1, {(XLEN_DEF-1){1'b0}}};

    // rs1 is signed for MULH, MULHSU, DIV and REM.
    function automatic logic op_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is signed for MULH, DIV and REM.
    function automatic logic op_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_core_step.sv
// ex_muldiv_unit_core_step
// Purely combinational iteration step shared by the multiplier and the divider.
// It chains BPC sub-steps, each of which retires one bit of the operation.
//   is_div     : 1 = restoring-divide sub-steps, 0 = shift-add multiply sub-steps
//   hi, lo     : working register pair (multiply: {partial high, multiplier/low
//                product}; divide: {partial remainder, dividend/quotient})
//   operand_b  : multiplicand or divisor magnitude
//   hi_next, lo_next : register pair after BPC sub-steps
module ex_muldiv_unit_core_step #(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] operand_b,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN-1:0] hi_chain [0:BPC];
    logic [XLEN-1:0] lo_chain [0:BPC];

    assign hi_chain[0] = hi;
    assign lo_chain[0] = lo;

    genvar gi;
    generate
        for (gi = 0; gi < BPC; gi++) begin : g_sub
            logic [XLEN:0]   mul_sum;
            logic [XLEN:0]   div_tmp;
            logic [XLEN-1:0] div_sub;
            logic            div_ge;

            // Multiply: add the multiplicand when the current multiplier bit
            // is set, then shift the {carry, hi, lo} triple right by one.
            assign mul_sum = {1'b0, hi_chain[gi]}
                           + (lo_chain[gi][0] ? {1'b0, operand_b} : {(XLEN+1){1'b0}});

            // Divide: shift the next dividend bit into the partial remainder
            // and subtract the divisor when it fits. The true difference is
            // always below 2^XLEN, so a modulo-XLEN subtract is exact.
            assign div_tmp = {hi_chain[gi], lo_chain[gi][XLEN-1]};
            assign div_ge  = (div_tmp >= {1'b0, operand_b});
            assign div_sub = div_tmp[XLEN-1:0] - operand_b;

            assign hi_chain[gi+1] = is_div ? (div_ge ? div_sub : div_tmp[XLEN-1:0])
                                           : mul_sum[XLEN:1];
            assign lo_chain[gi+1] = is_div ? {lo_chain[gi][XLEN-2:0], div_ge}
                                           : {mul_sum[0], lo_chain[gi][XLEN-1:1]};
        end
    endgenerate

    assign hi_next = hi_chain[BPC];
    assign lo_next = lo_chain[BPC];

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
// Multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// It accepts one op from ID/EX via in_valid/in_ready, iterates for XLEN/BPC
// cycles (or finishes in one cycle for divide-by-zero / signed overflow),
// then holds the result on out_valid until out_ready.
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global enable), flush_in (kill)
//   in_valid/in_ready, op_in (funct3), rs1_in, rs2_in, rd_in : request side
//   out_valid/out_ready, result_o, rd_o                      : result side
//   busy_o, busy_rd_o                                        : stall info for ID
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int BPC       = 1,
    parameter int REGADDR_W = 5
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op_in,
    input  logic [XLEN-1:0]      rs1_in,
    input  logic [XLEN-1:0]      rs2_in,
    input  logic [REGADDR_W-1:0] rd_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      result_o,
    output logic [REGADDR_W-1:0] rd_o,
    output logic                 busy_o,
    output logic [REGADDR_W-1:0] busy_rd_o
);

    localparam int STEPS = XLEN / BPC;
    localparam int CNT_W = $clog2(STEPS + 1);

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]           state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [2:0]           op_reg;
    logic [REGADDR_W-1:0] rd_reg;
    logic                 neg_res_reg;   // negate quotient / product at completion
    logic                 neg_rem_reg;   // remainder follows the dividend sign
    logic [XLEN-1:0]      hi_reg;
    logic [XLEN-1:0]      lo_reg;
    logic [XLEN-1:0]      b_reg;
    logic [XLEN-1:0]      result_reg;

    // ---------------- accept-side decode ----------------
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_by_zero, div_overflow, special_case;
    logic [XLEN-1:0] special_result;

    assign a_neg = op_signed_a(op_in) & rs1_in[XLEN-1];
    assign b_neg = op_signed_b(op_in) & rs2_in[XLEN-1];
    assign a_mag = a_neg ? -rs1_in : rs1_in;
    assign b_mag = b_neg ? -rs2_in : rs2_in;

    assign div_by_zero  = op_in[2] && (rs2_in == '0);
    assign div_overflow = ((op_in == OP_DIV) || (op_in == OP_REM))
                          && (rs1_in == MOST_NEG) && (rs2_in == ALL_ONES);
    assign special_case = div_by_zero || div_overflow;

    // op_in[1] selects the remainder within the divide class.
    always_comb begin
        special_result = '0;
        if (div_by_zero) begin
            special_result = op_in[1] ? rs1_in : ALL_ONES;
        end else if (div_overflow) begin
            special_result = op_in[1] ? '0 : rs1_in;
        end
    end

    // ---------------- iteration step ----------------
    logic [XLEN-1:0] step_hi, step_lo;

    ex_muldiv_unit_core_step #(
        .XLEN (XLEN),
        .BPC  (BPC)
    ) u_muldiv_core_step (
        .is_div    (op_reg[2]),
        .hi        (hi_reg),
        .lo        (lo_reg),
        .operand_b (b_reg),
        .hi_next   (step_hi),
        .lo_next   (step_lo)
    );

    // ---------------- completion / sign correction ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, final_result;

    assign prod_fix = neg_res_reg ? -{step_hi, step_lo} : {step_hi, step_lo};
    assign quo_fix  = neg_res_reg ? -step_lo : step_lo;
    assign rem_fix  = neg_rem_reg ? -step_hi : step_hi;

    always_comb begin
        final_result = '0;
        case (op_reg)
            OP_MUL:                     final_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU,
            OP_MULHU:                   final_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:            final_result = quo_fix;
            default:                    final_result = rem_fix;
        endcase
    end

    // ---------------- FSM and datapath registers ----------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            op_reg      <= '0;
            rd_reg      <= '0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            b_reg       <= '0;
            result_reg  <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                // Kill wins over any accept or consume in the same cycle.
                state_reg <= ST_IDLE;
                cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (in_valid) begin
                            op_reg      <= op_in;
                            rd_reg      <= rd_in;
                            neg_res_reg <= a_neg ^ b_neg;
                            neg_rem_reg <= a_neg;
                            hi_reg      <= '0;
                            lo_reg      <= a_mag;
                            b_reg       <= b_mag;
                            if (special_case) begin
                                result_reg <= special_result;
                                state_reg  <= ST_DONE;
                            end else begin
                                cnt_reg   <= CNT_W'(STEPS);
                                state_reg <= ST_CALC;
                            end
                        end
                    end
                    ST_CALC: begin
                        hi_reg <= step_hi;
                        lo_reg <= step_lo;
                        if (cnt_reg == CNT_W'(1)) begin
                            result_reg <= final_result;
                            cnt_reg    <= '0;
                            state_reg  <= ST_DONE;
                        end else begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end
                    end
                    ST_DONE: begin
                        if (out_ready) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    // ---------------- outputs ----------------
    assign in_ready  = (state_reg == ST_IDLE) && !rst_in;
    assign out_valid = (state_reg == ST_DONE);
    assign result_o  = result_reg;
    assign rd_o      = rd_reg;
    assign busy_o    = (state_reg != ST_IDLE);
    assign busy_rd_o = busy_o ? rd_reg : '0;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op_in;
    logic [31:0] rs1_in;
    logic [31:0] rs2_in;
    logic [4:0]  rd_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result_o;
    logic [4:0]  rd_o;
    logic        busy_o;
    logic [4:0]  busy_rd_o;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk_in = ~clk_in;

    ex_muldiv_unit #(
        .XLEN      (32),
        .BPC       (1),
        .REGADDR_W (5)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .flush_in  (flush_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_in     (op_in),
        .rs1_in    (rs1_in),
        .rs2_in    (rs2_in),
        .rd_in     (rd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result_o  (result_o),
        .rd_o      (rd_o),
        .busy_o    (busy_o),
        .busy_rd_o (busy_rd_o)
    );

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Present one op for a single cycle; returns at the negedge after the accept edge.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
        @(negedge clk_in);
        in_valid = 1'b1; op_in = op; rs1_in = a; rs2_in = b; rd_in = rd;
        @(negedge clk_in);
        in_valid = 1'b0;
    endtask

    // Edges from the accept edge up to out_valid (bounded).
    task automatic wait_valid(output int cycles);
        cycles = 1;
        while (!out_valid && cycles < 200) begin
            @(negedge clk_in);
            cycles++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        out_ready = 1'b1;
        send(v.op, v.a, v.b, v.rd);
        wait_valid(cyc);
        $display("%-8s a=0x%08h b=0x%08h rd=%0d -> result=0x%08h rd_o=%0d latency=%0d",
                 v.name, v.a, v.b, v.rd, result_o, rd_o, cyc);
        check({v.name, "_valid"},   64'(out_valid), 64'(1));
        check({v.name, "_latency"}, 64'(cyc), 64'(v.lat));
        check({v.name, "_result"},  64'(result_o), 64'(v.exp));
        check({v.name, "_rd"},      64'(rd_o), 64'(v.rd));
        check({v.name, "_busy_rd"}, 64'(busy_rd_o), 64'(v.rd));
        @(negedge clk_in);
        check({v.name, "_pulse"},   64'({out_valid, busy_o}), 64'(0));
    endtask

    initial begin
        int cyc;
        int seen;

        vecs[0]  = '{"MUL",     3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 33};
        vecs[1]  = '{"MULHU",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 33};
        vecs[2]  = '{"MULH",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0000_0000, 33};
        vecs[3]  = '{"MULHSU",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 33};
        vecs[4]  = '{"DIV",     3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd5,  32'hFFFF_FFFD, 33};
        vecs[5]  = '{"REM",     3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6,  32'hFFFF_FFFF, 33};
        vecs[6]  = '{"DIVU",    3'd5, 32'd100,       32'd7,         5'd7,  32'd14,        33};
        vecs[7]  = '{"REMU",    3'd7, 32'd100,       32'd7,         5'd8,  32'd2,         33};
        vecs[8]  = '{"DIV0",    3'd4, 32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF, 1};
        vecs[9]  = '{"REM0",    3'd6, 32'd5,         32'd0,         5'd10, 32'd5,         1};
        vecs[10] = '{"DIVOVF",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1};
        vecs[11] = '{"REMOVF",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000, 1};
        vecs[12] = '{"DIVU0",   3'd5, 32'h1234_5678, 32'd0,         5'd13, 32'hFFFF_FFFF, 1};
        vecs[13] = '{"MULX0",   3'd0, 32'h1234_5678, 32'h0000_0010, 5'd0,  32'h2345_6780, 33};
        vecs[14] = '{"DIVNEG",  3'd4, 32'h8000_0000, 32'h0000_0002, 5'd14, 32'hC000_0000, 33};
        vecs[15] = '{"REMU16",  3'd7, 32'hFFFF_FFFF, 32'h0000_0010, 5'd15, 32'h0000_000F, 33};

        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; in_valid = 1'b0;
        op_in = '0; rs1_in = '0; rs2_in = '0; rd_in = '0; out_ready = 1'b1;

        // ---- reset state ----
        repeat (2) @(negedge clk_in);
        check("reset_in_ready", 64'(in_ready), 64'(0));
        check("reset_outputs",  {27'd0, out_valid, result_o, rd_o, busy_o}, 64'(0));
        check("reset_busy_rd",  64'(busy_rd_o), 64'(0));
        rst_in = 1'b0;
        @(negedge clk_in);
        check("post_reset_in_ready", 64'(in_ready), 64'(1));

        // ---- table-driven vectors ----
        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        // ---- hold out_ready low in DONE for 5 cycles ----
        out_ready = 1'b0;
        send(3'd5, 32'd100, 32'd7, 5'd17);
        wait_valid(cyc);
        $display("HOLD     DIVU 100/7 rd=17 -> result=0x%08h latency=%0d", result_o, cyc);
        check("hold_latency", 64'(cyc), 64'(33));
        for (int k = 0; k < 5; k++) begin
            check("hold_state", {out_valid, busy_o, in_ready, rd_o, busy_rd_o, result_o},
                  {1'b1, 1'b1, 1'b0, 5'd17, 5'd17, 32'd14});
            @(negedge clk_in);
        end
        out_ready = 1'b1;
        @(negedge clk_in);
        check("hold_release", 64'({out_valid, busy_o, in_ready}), 64'(3'b001));

        // ---- rdy_in low for 4 cycles mid-CALC ----
        @(negedge clk_in);
        in_valid = 1'b1; op_in = 3'd5; rs1_in = 32'd1000; rs2_in = 32'd3; rd_in = 5'd18;
        @(negedge clk_in);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            if (cyc == 10) rdy_in = 1'b0;
            if (cyc == 14) rdy_in = 1'b1;
            @(negedge clk_in);
            cyc++;
        end
        rdy_in = 1'b1;
        $display("STALL    DIVU 1000/3 rd=18 -> result=0x%08h latency=%0d", result_o, cyc);
        check("stall_latency", 64'(cyc), 64'(37));
        check("stall_result",  64'(result_o), 64'(333));
        @(negedge clk_in);

        // ---- flush mid-CALC at cycle 10 ----
        @(negedge clk_in);
        in_valid = 1'b1; op_in = 3'd0; rs1_in = 32'd3; rs2_in = 32'd5; rd_in = 5'd19;
        @(negedge clk_in);
        in_valid = 1'b0;
        repeat (9) @(negedge clk_in);
        check("flush_pre_busy", 64'({busy_o, busy_rd_o}), 64'({1'b1, 5'd19}));
        flush_in = 1'b1;
        @(negedge clk_in);
        flush_in = 1'b0;
        check("flush_idle", 64'({out_valid, busy_o, in_ready, busy_rd_o}), 64'({3'b001, 5'd0}));
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) seen++;
            @(negedge clk_in);
        end
        $display("FLUSH    MUL 3*5 rd=19 killed at cycle 10, out_valid seen %0d times", seen);
        check("flush_no_valid", 64'(seen), 64'(0));
        run_vec('{"POSTFL", 3'd0, 32'd3, 32'd5, 5'd19, 32'd15, 33});

        // ---- flush coincident with accept ----
        @(negedge clk_in);
        in_valid = 1'b1; flush_in = 1'b1; op_in = 3'd4; rs1_in = 32'd5; rs2_in = 32'd0; rd_in = 5'd20;
        @(negedge clk_in);
        in_valid = 1'b0; flush_in = 1'b0;
        $display("FLACC    DIV 5/0 rd=20 with flush -> busy=%0d out_valid=%0d", busy_o, out_valid);
        check("flush_accept", 64'({out_valid, busy_o, in_ready}), 64'(3'b001));

        // ---- flush coincident with out_ready ----
        out_ready = 1'b0;
        send(3'd4, 32'd5, 32'd0, 5'd21);
        check("flcons_valid", 64'({out_valid, result_o}), 64'({1'b1, 32'hFFFF_FFFF}));
        out_ready = 1'b1; flush_in = 1'b1;
        @(negedge clk_in);
        flush_in = 1'b0;
        $display("FLCONS   DIV 5/0 rd=21 flushed while consumed -> busy=%0d", busy_o);
        check("flcons_idle", 64'({out_valid, busy_o, in_ready}), 64'(3'b001));

        // ---- rdy_in low ignores an accept ----
        rdy_in = 1'b0;
        @(negedge clk_in);
        in_valid = 1'b1; op_in = 3'd4; rs1_in = 32'd5; rs2_in = 32'd0; rd_in = 5'd22;
        @(negedge clk_in);
        in_valid = 1'b0;
        check("rdy_low_no_accept", 64'({out_valid, busy_o}), 64'(0));
        rdy_in = 1'b1;

        // ---- asynchronous reset mid-CALC ----
        send(3'd3, 32'hFFFF_FFFF, 32'h0000_0003, 5'd23);
        repeat (5) @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        $display("RESET    MULHU rd=23 reset mid-CALC -> busy=%0d result=0x%08h", busy_o, result_o);
        check("async_reset", {25'd0, in_ready, out_valid, busy_o, result_o, rd_o}, 64'(0));
        check("async_reset_busy_rd", 64'(busy_rd_o), 64'(0));
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        run_vec('{"POSTRST", 3'd3, 32'hFFFF_FFFF, 32'h0000_0003, 5'd23, 32'h0000_0002, 33});

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
